// File: rtl/spi_packet_scheduler.sv
// rtl/spi_packet_scheduler.sv - stages IMU updates, publishes a frozen 16-byte SPI packet while CS is idle
// Define SPI_TEST_PATTERN_EN to replace the packet image with a constant AA,11..FF test pattern.
module spi_packet_scheduler #(
  parameter logic [7:0]  HEADER_BYTE      = 8'hAA,
  parameter logic [23:0] HEARTBEAT_CYCLES = 24'd1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cs_n,
  input  logic         quat_valid,
  input  logic [15:0]  quat_w,
  input  logic [15:0]  quat_x,
  input  logic [15:0]  quat_y,
  input  logic [15:0]  quat_z,
  input  logic         gyro_valid,
  input  logic [15:0]  gyro_x,
  input  logic [15:0]  gyro_y,
  input  logic [15:0]  gyro_z,
  output logic [127:0] tx_packet,
  output logic         drdy,
  output logic         overrun,
  output logic [7:0]   seq
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t      state, state_next;
  logic        cs_meta, cs_s, cs_s_d;
  logic        cs_fall, cs_rise;
  logic        quat_fresh, gyro_fresh;
  logic [15:0] stage_qw, stage_qx, stage_qy, stage_qz;
  logic [15:0] stage_gx, stage_gy, stage_gz;
  logic [23:0] hb_count;
  logic        hb_expire;
  logic        publish;
  logic [7:0]  seq_new;
  logic        overrun_new;
  logic        hb_flag;
  logic [7:0]  status_byte;

  assign cs_fall = cs_s_d & ~cs_s;
  assign cs_rise = ~cs_s_d & cs_s;

  assign hb_expire   = (HEARTBEAT_CYCLES != 24'd0) && (hb_count == HEARTBEAT_CYCLES - 24'd1);
  assign seq_new     = seq + 8'd1;
  assign overrun_new = overrun | drdy;
  assign hb_flag     = hb_expire & ~(quat_fresh | gyro_fresh);
  assign status_byte = {seq_new[3:0], hb_flag, overrun_new, gyro_fresh, quat_fresh};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Raw cs_n is also required high so a select that is still in the synchronizer blocks a publish.
  always_comb begin
    state_next = state;
    publish    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = LOCKED;
        end else if (cs_s && cs_n && (quat_fresh || gyro_fresh || hb_expire)) begin
          publish = 1'b1;
        end
      end
      LOCKED: begin
        if (cs_rise) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_meta <= 1'b1;
      cs_s    <= 1'b1;
      cs_s_d  <= 1'b1;
    end else begin
      cs_meta <= cs_n;
      cs_s    <= cs_meta;
      cs_s_d  <= cs_s;
    end
  end

  // A valid in the publish cycle wins over the clear, so its data is carried to the next packet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quat_fresh <= 1'b0;
      gyro_fresh <= 1'b0;
      stage_qw   <= 16'h0;
      stage_qx   <= 16'h0;
      stage_qy   <= 16'h0;
      stage_qz   <= 16'h0;
      stage_gx   <= 16'h0;
      stage_gy   <= 16'h0;
      stage_gz   <= 16'h0;
    end else begin
      if (quat_valid) begin
        stage_qw   <= quat_w;
        stage_qx   <= quat_x;
        stage_qy   <= quat_y;
        stage_qz   <= quat_z;
        quat_fresh <= 1'b1;
      end else if (publish) begin
        quat_fresh <= 1'b0;
      end
      if (gyro_valid) begin
        stage_gx   <= gyro_x;
        stage_gy   <= gyro_y;
        stage_gz   <= gyro_z;
        gyro_fresh <= 1'b1;
      end else if (publish) begin
        gyro_fresh <= 1'b0;
      end
    end
  end

  // Overrun only changes on a publish, so on CS release it always equals the bit the MCU just read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq     <= 8'd0;
      drdy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (publish) begin
        seq     <= seq_new;
        drdy    <= 1'b1;
        overrun <= overrun_new;
      end else if (state == IDLE && cs_fall) begin
        drdy <= 1'b0;
      end
      if (state == LOCKED && cs_rise) begin
        overrun <= 1'b0;
      end
    end
  end

  // The counter parks at expiry so a heartbeat blocked by CS still fires on the next idle cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hb_count <= 24'd0;
    end else if (publish) begin
      hb_count <= 24'd0;
    end else if (state == IDLE && !hb_expire) begin
      hb_count <= hb_count + 24'd1;
    end
  end

`ifdef SPI_TEST_PATTERN_EN
  assign tx_packet = 128'hAA11_2233_4455_6677_8899_AABB_CCDD_EEFF;
`else
  logic [127:0] tx_image;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_image <= {HEADER_BYTE, 120'h0};
    end else if (publish) begin
      tx_image <= {HEADER_BYTE, stage_qw, stage_qx, stage_qy, stage_qz,
                   stage_gx, stage_gy, stage_gz, status_byte};
    end
  end

  assign tx_packet = tx_image;
`endif

endmodule

// File: tb/tb_spi_packet_scheduler.sv
// tb/tb_spi_packet_scheduler.sv - directed self-checking bench for spi_packet_scheduler
module tb_spi_packet_scheduler;

  logic         clk;
  logic         rst_n;
  logic         cs_n;
  logic         quat_valid;
  logic [15:0]  quat_w, quat_x, quat_y, quat_z;
  logic         gyro_valid;
  logic [15:0]  gyro_x, gyro_y, gyro_z;
  logic [127:0] tx_packet;
  logic         drdy;
  logic         overrun;
  logic [7:0]   seq;

  int n_cmp;
  int n_fail;

  logic [127:0] exp_pkt;
  logic [63:0]  quat_c;
  logic [47:0]  gyro_b;

  spi_packet_scheduler #(
    .HEADER_BYTE      (8'hAA),
    .HEARTBEAT_CYCLES (24'd100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .quat_valid (quat_valid),
    .quat_w     (quat_w),
    .quat_x     (quat_x),
    .quat_y     (quat_y),
    .quat_z     (quat_z),
    .gyro_valid (gyro_valid),
    .gyro_x     (gyro_x),
    .gyro_y     (gyro_y),
    .gyro_z     (gyro_z),
    .tx_packet  (tx_packet),
    .drdy       (drdy),
    .overrun    (overrun),
    .seq        (seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_quat(input logic [63:0] q);
    {quat_w, quat_x, quat_y, quat_z} = q;
    quat_valid = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cs_n = 1'b1;
    quat_valid = 1'b0; gyro_valid = 1'b0;
    {quat_w, quat_x, quat_y, quat_z} = 64'h0;
    {gyro_x, gyro_y, gyro_z} = 48'h0;
    tick(2);
    exp_pkt = {8'hAA, 120'h0};
    n_cmp++; if (tx_packet !== exp_pkt) begin n_fail++; $display("FAIL reset_tx: got %h want %h", tx_packet, exp_pkt); end
    n_cmp++; if (drdy !== 1'b0) begin n_fail++; $display("FAIL reset_drdy: got %b want 0", drdy); end
    n_cmp++; if (seq !== 8'd0) begin n_fail++; $display("FAIL reset_seq: got %0d want 0", seq); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_quat_publish;
    set_quat(64'h1234_5678_9ABC_DEF0);
    tick(1);
    quat_valid = 1'b0;
    n_cmp++; if (drdy !== 1'b0) begin n_fail++; $display("FAIL quat_latency_drdy: got %b want 0", drdy); end
    n_cmp++; if (tx_packet !== {8'hAA, 120'h0}) begin n_fail++; $display("FAIL quat_latency_tx: got %h want %h", tx_packet, {8'hAA, 120'h0}); end
    tick(1);
    exp_pkt = {8'hAA, 64'h1234_5678_9ABC_DEF0, 48'h0, 8'h11};
    n_cmp++; if (tx_packet !== exp_pkt) begin n_fail++; $display("FAIL quat_tx: got %h want %h", tx_packet, exp_pkt); end
    n_cmp++; if (drdy !== 1'b1) begin n_fail++; $display("FAIL quat_drdy: got %b want 1", drdy); end
    n_cmp++; if (seq !== 8'd1) begin n_fail++; $display("FAIL quat_seq: got %0d want 1", seq); end
  endtask

  task automatic test_locked;
    int waited;
    cs_n = 1'b0;
    tick(3);
    n_cmp++; if (drdy !== 1'b0) begin n_fail++; $display("FAIL lock_drdy: got %b want 0", drdy); end
    gyro_x = 16'h0102; gyro_y = 16'h0; gyro_z = 16'h0;
    gyro_valid = 1'b1;
    tick(1);
    gyro_valid = 1'b0;
    tick(3);
    exp_pkt = {8'hAA, 64'h1234_5678_9ABC_DEF0, 48'h0, 8'h11};
    n_cmp++; if (tx_packet !== exp_pkt) begin n_fail++; $display("FAIL lock_tx_frozen: got %h want %h", tx_packet, exp_pkt); end
    n_cmp++; if (seq !== 8'd1) begin n_fail++; $display("FAIL lock_seq: got %0d want 1", seq); end
    cs_n = 1'b1;
    waited = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (seq !== 8'd1) begin waited = i; break; end
    end
    n_cmp++; if (waited !== 4) begin n_fail++; $display("FAIL unlock_publish_cycles: got %0d want 4", waited); end
    exp_pkt = {8'hAA, 64'h1234_5678_9ABC_DEF0, 48'h0102_0000_0000, 8'h22};
    n_cmp++; if (tx_packet !== exp_pkt) begin n_fail++; $display("FAIL gyro_tx: got %h want %h", tx_packet, exp_pkt); end
    n_cmp++; if (seq !== 8'd2) begin n_fail++; $display("FAIL gyro_seq: got %0d want 2", seq); end
    n_cmp++; if (drdy !== 1'b1) begin n_fail++; $display("FAIL gyro_drdy: got %b want 1", drdy); end
  endtask

  task automatic test_back_to_back_overrun;
    gyro_b = 48'h0102_0000_0000;
    set_quat(64'h1111_2222_3333_4444);
    tick(1);
    set_quat(64'h5555_6666_7777_8888);
    tick(1);
    quat_valid = 1'b0;
    exp_pkt = {8'hAA, 64'h1111_2222_3333_4444, gyro_b, 8'h35};
    n_cmp++; if (tx_packet !== exp_pkt) begin n_fail++; $display("FAIL ovr_first_tx: got %h want %h", tx_packet, exp_pkt); end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
    tick(1);
    exp_pkt = {8'hAA, 64'h5555_6666_7777_8888, gyro_b, 8'h45};
    n_cmp++; if (tx_packet !== exp_pkt) begin n_fail++; $display("FAIL ovr_second_tx: got %h want %h", tx_packet, exp_pkt); end
    n_cmp++; if (seq !== 8'd4) begin n_fail++; $display("FAIL ovr_seq: got %0d want 4", seq); end
    cs_n = 1'b0; tick(4);
    cs_n = 1'b1; tick(4);
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_cleared: got %b want 0", overrun); end
    n_cmp++; if (drdy !== 1'b0) begin n_fail++; $display("FAIL ovr_read_drdy: got %b want 0", drdy); end
    n_cmp++; if (seq !== 8'd4) begin n_fail++; $display("FAIL ovr_no_spurious: got %0d want 4", seq); end
    quat_c = 64'hCAFE_BEEF_0001_FFFF;
    set_quat(quat_c);
    tick(1);
    quat_valid = 1'b0;
    tick(1);
    exp_pkt = {8'hAA, quat_c, gyro_b, 8'h51};
    n_cmp++; if (tx_packet !== exp_pkt) begin n_fail++; $display("FAIL ovr_after_read_tx: got %h want %h", tx_packet, exp_pkt); end
  endtask

  task automatic test_heartbeat;
    int waited;
    cs_n = 1'b0; tick(4);
    cs_n = 1'b1; tick(4);
    waited = 0;
    for (int i = 1; i <= 200; i++) begin
      tick(1);
      if (seq !== 8'd5) begin waited = i; break; end
    end
    n_cmp++; if (waited == 0) begin n_fail++; $display("FAIL hb_first_timeout: got no publish want publish within 200"); end
    exp_pkt = {8'hAA, quat_c, gyro_b, 8'h68};
    n_cmp++; if (tx_packet !== exp_pkt) begin n_fail++; $display("FAIL hb_first_tx: got %h want %h", tx_packet, exp_pkt); end
    n_cmp++; if (drdy !== 1'b1) begin n_fail++; $display("FAIL hb_drdy: got %b want 1", drdy); end
    waited = 0;
    for (int i = 1; i <= 150; i++) begin
      tick(1);
      if (seq !== 8'd6) begin waited = i; break; end
    end
    n_cmp++; if (waited !== 100) begin n_fail++; $display("FAIL hb_interval: got %0d want 100", waited); end
    exp_pkt = {8'hAA, quat_c, gyro_b, 8'h7C};
    n_cmp++; if (tx_packet !== exp_pkt) begin n_fail++; $display("FAIL hb_second_tx: got %h want %h", tx_packet, exp_pkt); end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL hb_overrun: got %b want 1", overrun); end
  endtask

  task automatic test_reset_locked;
    cs_n = 1'b0;
    tick(3);
    set_quat(64'h7777_7777_7777_7777);
    tick(1);
    quat_valid = 1'b0;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    exp_pkt = {8'hAA, 120'h0};
    n_cmp++; if (tx_packet !== exp_pkt) begin n_fail++; $display("FAIL rstlock_tx: got %h want %h", tx_packet, exp_pkt); end
    n_cmp++; if (seq !== 8'd0) begin n_fail++; $display("FAIL rstlock_seq: got %0d want 0", seq); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstlock_overrun: got %b want 0", overrun); end
    rst_n = 1'b1; cs_n = 1'b1;
    tick(20);
    n_cmp++; if (seq !== 8'd0) begin n_fail++; $display("FAIL rstlock_no_publish: got seq %0d want 0", seq); end
    n_cmp++; if (drdy !== 1'b0) begin n_fail++; $display("FAIL rstlock_drdy: got %b want 0", drdy); end
    set_quat(64'h0A0B_0C0D_0E0F_1011);
    {gyro_x, gyro_y, gyro_z} = 48'h2021_2223_2425;
    gyro_valid = 1'b1;
    tick(1);
    quat_valid = 1'b0; gyro_valid = 1'b0;
    tick(1);
    exp_pkt = {8'hAA, 64'h0A0B_0C0D_0E0F_1011, 48'h2021_2223_2425, 8'h13};
    n_cmp++; if (tx_packet !== exp_pkt) begin n_fail++; $display("FAIL both_valid_tx: got %h want %h", tx_packet, exp_pkt); end
    n_cmp++; if (seq !== 8'd1) begin n_fail++; $display("FAIL both_valid_seq: got %0d want 1", seq); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset;
    test_quat_publish;
    test_locked;
    test_back_to_back_overrun;
    test_heartbeat;
    test_reset_locked;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
